way_fill_decoder: RTL and testbench
===================================

// Module: way_fill_decoder
// PURPOSE
//  Sequential binary-to-one-hot way decoder for L2 line fills. Accepts a victim way index from
//  replacement logic and drives a one-hot way write-enable for BEATS consecutive data beats.
//  Sits between the victim-select path and the data/tag array write ports; inverse of the
//  one-hot-to-index hit-way encoder.
// PARAMETERS
//  WAYS   8  number of cache ways; one-hot output width (need not be a power of 2, >= 2)
//  BEATS  4  data beats per line fill (>= 1)
// PORTS
//  clk        in   1                 clock; all logic on rising edge
//  reset      in   1                 synchronous, active-high reset
//  req_valid  in   1                 fill request present
//  req_ready  out  1                 block can accept a request this cycle
//  req_way    in   $clog2(WAYS)      binary victim way index
//  stall      in   1                 fill data not available this cycle; hold current beat
//  way_we     out  WAYS              one-hot array write-enable (all-zero when idle/stalled)
//  beat_idx   out  $clog2(BEATS)+1   current beat number, 0..BEATS-1
//  last       out  1                 current enabled beat is the final beat
//  done       out  1                 one-cycle pulse, coincident with the final enabled beat
//  err        out  1                 one-cycle pulse: accepted req_way >= WAYS
//  abort      in   1                 only when WAY_FILL_ABORT_EN defined; see CONFIGURATION
// BEHAVIOUR
//  - Reset: state IDLE; way_we=0, beat_idx=0, last=0, done=0, err=0, req_ready=1 the cycle after.
//    Reset mid-fill drops the fill; no done pulse. Reset wins over all other inputs.
//  - All outputs except req_ready are registered; req_ready is combinational from state/counter.
//  - States: IDLE, FILL.
//    IDLE: req_ready=1. On req_valid && req_way<WAYS -> latch way, beat counter=0, go FILL.
//          On req_valid && req_way>=WAYS -> err=1 next cycle, stay IDLE, way_we stays 0.
//    FILL: each non-stalled cycle drives way_we=1<<way, beat_idx=counter; counter increments.
//          stall=1 -> way_we=0, counter, beat_idx and last held, no advance.
//          Final beat (counter==BEATS-1, !stall) -> last=1, done=1 on that same output cycle.
  //  - Latency: request accepted at edge N -> first way_we asserted in cycle N+1.
//  - Back-to-back: req_ready=1 also in FILL on the final non-stalled beat; a request accepted
//    there starts its beat 0 the very next cycle (no bubble). Otherwise req_ready=0 in FILL.
//  - BEATS=1: every accepted request produces one way_we cycle with last=done=1.
//  - way_we is always zero or exactly one-hot; never more than one bit set.
//  - Counter width $clog2(BEATS)+1: no wrap-around inside a fill; it resets to 0 per request.
// CONFIGURATION
//  WAY_FILL_ABORT_EN defined: abort port exists. abort=1 in FILL -> way_we=0 that cycle, return
//    to IDLE, no done pulse; abort in IDLE is ignored. abort has priority over stall and last beat.
//  Not defined: abort port absent; every accepted in-range fill runs to completion.
// STRUCTURE
//  - cache_pkg: WAYS/BEATS defaults, way_idx_t, beat_idx_t, fill_state_e {IDLE, FILL}.
//  - Sub-module way_onehot_dec: combinational binary->one-hot with in-range flag;
//    instantiated once. The FSM and counter live in way_fill_decoder.
// TESTING
//  1. reset=1 two cycles, then 0 -> way_we=0, done=0, err=0, req_ready=1.
//  2. WAYS=8, BEATS=4, req_way=5, no stall -> way_we=8'b0010_0000 for 4 cycles, beat_idx 0..3,
//     last=done=1 on beat 3.
//  3. Same req, stall high during beat 1 for 2 cycles -> way_we=0 for those cycles, beat_idx
//     holds 1, fill finishes 2 cycles later.
//  4. req_way=2, then req_way=7 presented on the final beat -> way 7 beat 0 the next cycle.
//  5. WAYS=6, req_way=6 -> err pulse, way_we stays 0, req_ready stays 1.
//  6. reset asserted at beat 2 (and with WAY_FILL_ABORT_EN, abort at beat 1) -> way_we=0 next
//     cycle, no done, IDLE.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared cache-fill types and default geometry for the way fill path.
package cache_pkg;
  localparam int WAYS_DEF  = 8;
  localparam int BEATS_DEF = 4;

  typedef logic [$clog2(WAYS_DEF)-1:0] way_idx_t;
  typedef logic [$clog2(BEATS_DEF):0]  beat_idx_t;

  typedef enum logic {IDLE, FILL} fill_state_e;
endpackage

// File: rtl/way_fill_decoder_onehot.sv
// Combinational binary way index -> one-hot, with an in-range flag for
// non-power-of-two way counts (out-of-range indices decode to all zero).
module way_onehot_dec #(
  parameter int WAYS = 8,
  parameter int IW   = $clog2(WAYS)
) (
  input  logic [IW-1:0]   idx,
  output logic [WAYS-1:0] onehot,
  output logic            in_range
);
  for (genvar i = 0; i < WAYS; i++) begin : g_bit
    assign onehot[i] = (idx == IW'(i));
  end

  assign in_range = ({1'b0, idx} < (IW+1)'(WAYS));
endmodule

// File: rtl/way_fill_decoder.sv
// Sequential victim-way -> one-hot write-enable driver for BEATS-beat line fills.
// Optional WAY_FILL_ABORT_EN adds an abort input that cancels an in-flight fill.
module way_fill_decoder
  import cache_pkg::*;
#(
  parameter int WAYS  = WAYS_DEF,
  parameter int BEATS = BEATS_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [$clog2(WAYS)-1:0]  req_way,
  input  logic                     stall,
`ifdef WAY_FILL_ABORT_EN
  input  logic                     abort,
`endif
  output logic [WAYS-1:0]          way_we,
  output logic [$clog2(BEATS):0]   beat_idx,
  output logic                     last,
  output logic                     done,
  output logic                     err
);
  localparam int IW = $clog2(WAYS);
  localparam int CW = $clog2(BEATS) + 1;

  fill_state_e     state;
  logic [WAYS-1:0] way_oh_q;
  logic [CW-1:0]   cnt;
  logic [WAYS-1:0] dec_oh;
  logic            dec_ok;
  logic            abort_i;
  logic            final_beat;
  logic            accept;

`ifdef WAY_FILL_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  way_onehot_dec #(.WAYS(WAYS), .IW(IW)) u_dec (
    .idx      (req_way),
    .onehot   (dec_oh),
    .in_range (dec_ok)
  );

  // The final non-stalled beat frees the FSM, so the next request can be
  // taken in the same cycle and its beat 0 follows without a bubble.
  assign final_beat = (state == FILL) && !abort_i && !stall && (cnt == CW'(BEATS-1));
  assign req_ready  = (state == IDLE) || final_beat;
  assign accept     = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      way_oh_q <= '0;
      cnt      <= '0;
      way_we   <= '0;
      beat_idx <= '0;
      last     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      way_we <= '0;
      done   <= 1'b0;
      err    <= accept && !dec_ok;
      case (state)
        IDLE: last <= 1'b0;
        FILL: begin
          if (abort_i) begin
            last  <= 1'b0;
            state <= IDLE;
          end else if (!stall) begin
            way_we   <= way_oh_q;
            beat_idx <= cnt;
            last     <= final_beat;
            done     <= final_beat;
            cnt      <= cnt + 1'b1;
            if (final_beat) state <= IDLE;
          end
        end
      endcase
      // A new accept overrides the return to IDLE on a final beat.
      if (accept && dec_ok) begin
        state    <= FILL;
        way_oh_q <= dec_oh;
        cnt      <= '0;
      end
    end
  end
endmodule

// File: tb/tb_way_fill_decoder.sv
// Randomized scoreboard bench for way_fill_decoder (WAYS=6 so out-of-range ways occur).
module tb_way_fill_decoder;
  localparam int W = 6;
  localparam int B = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [2:0]   req_way = '0;
  logic         stall = 1'b0;
`ifdef WAY_FILL_ABORT_EN
  logic         abort = 1'b0;
`endif
  logic [W-1:0] way_we;
  logic [2:0]   beat_idx;
  logic         last, done, err;

  way_fill_decoder #(.WAYS(W), .BEATS(B)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_way   (req_way),
    .stall     (stall),
`ifdef WAY_FILL_ABORT_EN
    .abort     (abort),
`endif
    .way_we    (way_we),
    .beat_idx  (beat_idx),
    .last      (last),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    logic [W-1:0] we;
    logic [2:0]   bi;
    logic         last;
    logic         done;
    logic         err;
  } rec_t;

  rec_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   started = 0;

  // Transaction-level model: a fill is a way plus a count of beats already issued.
  bit busy = 0;
  int mway = 0;
  int k = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle of inputs; record what the outputs must show after the edge.
  task automatic step(input bit r, input bit v, input int w, input bit st);
    rec_t rc;
    bit   ery, have;
    reset = r; req_valid = v; req_way = 3'(w); stall = st;
    ery = !busy || (k == B-1 && !st);
    #1;
    if (started && !r) chk("req_ready", 32'(req_ready), 32'(ery));
    if (r) begin
      busy = 0; k = 0;
    end else begin
      rc.cyc = cyc + 1; rc.we = '0; rc.bi = '0; rc.last = 0; rc.done = 0; rc.err = 0;
      have = 0;
      if (busy && !st) begin
        rc.we = W'(1 << mway); rc.bi = 3'(k);
        rc.last = (k == B-1); rc.done = (k == B-1);
        have = 1; k++;
        if (k == B) busy = 0;
      end
      if (v && ery) begin
        if (w >= W) begin rc.err = 1; have = 1; end
        else begin busy = 1; mway = w; k = 0; end
      end
      if (have) q.push_back(rc);
    end
    @(negedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (started) begin
      if (q.size() > 0 && q[0].cyc == cyc) begin
        rec_t r;
        r = q.pop_front();
        chk("way_we", 32'(way_we), 32'(r.we));
        chk("done", 32'(done), 32'(r.done));
        chk("err", 32'(err), 32'(r.err));
        if (r.we != 0) begin
          chk("beat_idx", 32'(beat_idx), 32'(r.bi));
          chk("last", 32'(last), 32'(r.last));
        end
      end else begin
        chk("idle_outs", {29'd0, |way_we, done, err}, 32'd0);
      end
      chk("onehot", 32'($countones(way_we) <= 1), 32'd1);
    end
  end

  initial begin
    @(negedge clk); #1;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    started = 1;
    chk("rst_way_we", 32'(way_we), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    // Plain fill of way 5.
    step(0, 1, 5, 0);
    repeat (6) step(0, 0, 0, 0);
    // Fill of way 5 with two stalled cycles on beat 1.
    step(0, 1, 5, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    repeat (5) step(0, 0, 0, 0);
    // Way 2, then way 5 presented on the final beat: no bubble.
    step(0, 1, 2, 0);
    repeat (3) step(0, 0, 0, 0);
    step(0, 1, 5, 0);
    repeat (6) step(0, 0, 0, 0);
    // Out-of-range ways raise err only.
    step(0, 1, 6, 0);
    step(0, 1, 7, 0);
    repeat (2) step(0, 0, 0, 0);
    // Reset in the middle of a fill.
    step(0, 1, 3, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (6) step(0, 0, 0, 0);
    // Random traffic.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 7)), $urandom_range(0, 3) == 0);
    repeat (B + 3) step(0, 0, 0, 0);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
